// File: rtl/cache_pkg.sv
// Shared types, geometry and helpers for the direct-mapped write-through L1 data cache.
package cache_pkg;

    localparam int unsigned RISC_data   = 32;
    localparam int unsigned main_data   = 128;
    localparam int unsigned CACHE_LINES = 32;
    localparam int unsigned ADDR_W      = 10;

    localparam int unsigned OFFSET_W = 2;
    localparam int unsigned INDEX_W  = $clog2(CACHE_LINES);
    localparam int unsigned TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam int unsigned BLOCK_W  = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, DRAIN} state_e;

    function automatic logic [RISC_data-1:0] word_sel(input logic [main_data-1:0] line,
                                                      input logic [OFFSET_W-1:0]  off);
        return line[RISC_data*off +: RISC_data];
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Block-memory bus between the cache controller (master) and data_memory (slave).
interface cache_controller_if;
    import cache_pkg::*;

    logic                 mem_we;
    logic                 mem_re;
    logic [BLOCK_W-1:0]   mem_addr;
    logic [OFFSET_W-1:0]  mem_word_loc;
    logic [RISC_data-1:0] mem_wdata;
    logic [main_data-1:0] mem_rdata;
    logic                 mem_done;

    modport master (
        output mem_we, mem_re, mem_addr, mem_word_loc, mem_wdata,
        input  mem_rdata, mem_done
    );

    modport slave (
        input  mem_we, mem_re, mem_addr, mem_word_loc, mem_wdata,
        output mem_rdata, mem_done
    );

endinterface

// File: rtl/cache_array.sv
// Tag/valid/data storage: one combinational read port, one write port (line fill or word update).
module cache_array
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INDEX_W-1:0]   rd_index,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [main_data-1:0] rd_line,
    input  logic                 wr_en,
    input  logic                 wr_fill,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [main_data-1:0] wr_line,
    input  logic [OFFSET_W-1:0]  wr_offset,
    input  logic [RISC_data-1:0] wr_word
);

    logic [CACHE_LINES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q  [CACHE_LINES];
    logic [main_data-1:0]   data_q [CACHE_LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en && wr_fill) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Word updates only happen on store hits, so the tag is already correct.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_fill) begin
                tag_q[wr_index]  <= wr_tag;
                data_q[wr_index] <= wr_line;
            end else begin
                data_q[wr_index][RISC_data*wr_offset +: RISC_data] <= wr_word;
            end
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Optional CACHE_STATS_EN builds saturating hit/miss counters; otherwise they read 0.
module cache_controller
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [RISC_data-1:0] cpu_wdata,
    output logic [RISC_data-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 cpu_stall,
    cache_controller_if.master   mem,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);

    state_e               state_q;
    logic [RISC_data-1:0] cpu_rdata_q;
    logic                 cpu_ready_q;
    logic                 cpu_stall_q;
    logic                 mem_we_q;
    logic                 mem_re_q;
    logic [BLOCK_W-1:0]   mem_addr_q;
    logic [OFFSET_W-1:0]  mem_word_loc_q;
    logic [RISC_data-1:0] mem_wdata_q;

    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [main_data-1:0] rd_line;
    logic                 hit;
    logic                 idle_req;

    logic                 wr_en;
    logic                 wr_fill;
    logic [INDEX_W-1:0]   wr_index;
    logic [TAG_W-1:0]     wr_tag;

    cache_array u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (cpu_addr[OFFSET_W +: INDEX_W]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_en     (wr_en),
        .wr_fill   (wr_fill),
        .wr_index  (wr_index),
        .wr_tag    (wr_tag),
        .wr_line   (mem.mem_rdata),
        .wr_offset (cpu_addr[OFFSET_W-1:0]),
        .wr_word   (cpu_wdata)
    );

    assign hit      = rd_valid && (rd_tag == cpu_addr[ADDR_W-1 -: TAG_W]);
    assign idle_req = (state_q == IDLE) && cpu_req;

    // Fills use the latched block address; store hits patch one word from the live request.
    always_comb begin
        wr_en    = 1'b0;
        wr_fill  = 1'b0;
        wr_index = cpu_addr[OFFSET_W +: INDEX_W];
        wr_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
        if (idle_req && cpu_we && hit) begin
            wr_en = 1'b1;
        end else if ((state_q == MEM_RD) && mem.mem_done) begin
            wr_en    = 1'b1;
            wr_fill  = 1'b1;
            wr_index = mem_addr_q[INDEX_W-1:0];
            wr_tag   = mem_addr_q[BLOCK_W-1 -: TAG_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cpu_rdata_q    <= '0;
            cpu_ready_q    <= 1'b0;
            cpu_stall_q    <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_re_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_word_loc_q <= '0;
            mem_wdata_q    <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        mem_addr_q     <= cpu_addr[ADDR_W-1:OFFSET_W];
                        mem_word_loc_q <= cpu_addr[OFFSET_W-1:0];
                        if (cpu_we) begin
                            mem_wdata_q <= cpu_wdata;
                            mem_we_q    <= 1'b1;
                            cpu_stall_q <= 1'b1;
                            state_q     <= MEM_WR;
                        end else if (hit) begin
                            cpu_rdata_q <= word_sel(rd_line, cpu_addr[OFFSET_W-1:0]);
                            cpu_ready_q <= 1'b1;
                        end else begin
                            mem_re_q    <= 1'b1;
                            cpu_stall_q <= 1'b1;
                            state_q     <= MEM_RD;
                        end
                    end
                end
                MEM_RD: begin
                    if (mem.mem_done) begin
                        cpu_rdata_q <= word_sel(mem.mem_rdata, mem_word_loc_q);
                        cpu_ready_q <= 1'b1;
                        mem_re_q    <= 1'b0;
                        state_q     <= DRAIN;
                    end
                end
                MEM_WR: begin
                    if (mem.mem_done) begin
                        cpu_ready_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Let the trailing mem_done cycle pass before accepting new work.
                    if (!mem.mem_done) begin
                        cpu_stall_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata        = cpu_rdata_q;
    assign cpu_ready        = cpu_ready_q;
    assign cpu_stall        = cpu_stall_q;
    assign mem.mem_we       = mem_we_q;
    assign mem.mem_re       = mem_re_q;
    assign mem.mem_addr     = mem_addr_q;
    assign mem.mem_word_loc = mem_word_loc_q;
    assign mem.mem_wdata    = mem_wdata_q;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (idle_req) begin
            if (hit) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: directed scenarios plus random loads/stores against a line-level model.
module tb_cache_controller;
    import cache_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cpu_req;
    logic                 cpu_we;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [RISC_data-1:0] cpu_wdata;
    logic [RISC_data-1:0] cpu_rdata;
    logic                 cpu_ready;
    logic                 cpu_stall;
    logic [15:0]          hit_count;
    logic [15:0]          miss_count;

    cache_controller_if mif ();

    cache_controller dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .cpu_stall  (cpu_stall),
        .mem        (mif),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [main_data-1:0] mem_blk [256];
    logic [main_data-1:0] ref_mem [256];
    bit                   m_valid [CACHE_LINES];
    logic [TAG_W-1:0]     m_tag   [CACHE_LINES];
    int                   m_hits = 0;
    int                   m_misses = 0;
    int                   reads = 0;
    int                   writes = 0;
    int                   force_lat = -1;
    int                   force_hold = 0;
    logic [BLOCK_W-1:0]   exp_blk = '0;
    logic [OFFSET_W-1:0]  exp_loc = '0;
    logic [RISC_data-1:0] exp_wd = '0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Memory slave: random latency, mem_done raised on negedge for one or two posedges.
    int lat = -1;
    int hold = 0;
    always @(negedge clk) begin
        if (rst) begin
            mif.mem_done = 1'b0;
            lat = -1;
            hold = 0;
        end else begin
            if (mif.mem_we || mif.mem_re) check_eq("excl", mif.mem_we & mif.mem_re, 0);
            if (hold > 0) begin
                hold--;
                if (hold == 0) mif.mem_done = 1'b0;
            end else if (mif.mem_we || mif.mem_re) begin
                if (lat < 0) lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                if (lat == 0) begin
                    lat = -1;
                    check_eq("mem_addr", mif.mem_addr, exp_blk);
                    if (mif.mem_we) begin
                        check_eq("mem_loc", mif.mem_word_loc, exp_loc);
                        check_eq("mem_wdata", mif.mem_wdata, exp_wd);
                        mem_blk[mif.mem_addr][32*mif.mem_word_loc +: 32] = mif.mem_wdata;
                        writes++;
                    end else begin
                        mif.mem_rdata = mem_blk[mif.mem_addr];
                        reads++;
                    end
                    mif.mem_done = 1'b1;
                    hold = (force_hold > 0) ? force_hold : int'($urandom_range(1, 2));
                end else begin
                    lat--;
                end
            end
        end
    end

    task automatic do_op(input bit we, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                         input bit b2b, output logic [31:0] rd);
        logic [INDEX_W-1:0] idx;
        logic [TAG_W-1:0]   tg;
        bit exp_hit, was_idle, got;
        int cyc, r0, w0, extra, n;
        idx = addr[OFFSET_W +: INDEX_W];
        tg  = addr[ADDR_W-1 -: TAG_W];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        @(negedge clk);
        was_idle = !cpu_stall;
        exp_blk = addr[ADDR_W-1:OFFSET_W];
        exp_loc = addr[OFFSET_W-1:0];
        exp_wd  = wd;
        r0 = reads;
        w0 = writes;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1 && was_idle) check_eq("stall", cpu_stall, !(exp_hit && !we));
            if (cpu_ready) got = 1'b1;
        end
        cpu_req = 1'b0;
        rd = cpu_rdata;
        check_eq("ready", got, 1);
        if (!we) check_eq("rdata", cpu_rdata, ref_mem[exp_blk][32*exp_loc +: 32]);
        if (!we && exp_hit && was_idle) check_eq("hit_lat", cyc, 1);
        check_eq("reads", reads - r0, (!we && !exp_hit) ? 1 : 0);
        check_eq("writes", writes - w0, we ? 1 : 0);
        if (we) ref_mem[exp_blk][32*exp_loc +: 32] = wd;
        else if (!exp_hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx] = tg;
        end
        if (exp_hit) m_hits++;
        else m_misses++;
        if (!b2b) begin
            extra = 0;
            n = 0;
            @(posedge clk); #1;
            if (cpu_ready) extra++;
            while (cpu_stall && n < 50) begin
                @(posedge clk); #1;
                n++;
                if (cpu_ready) extra++;
            end
            check_eq("one_rdy", extra, 0);
            check_eq("idle", cpu_stall, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int nbad, rdy_cnt;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem_blk[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        mem_blk[8'h21] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_blk[i];
        for (int i = 0; i < CACHE_LINES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", cpu_ready, 0);
        check_eq("rst_stall", cpu_stall, 0);
        check_eq("rst_rdata", cpu_rdata, 0);
        check_eq("rst_we_re", {mif.mem_we, mif.mem_re}, 0);
        check_eq("rst_maddr", {mif.mem_addr, mif.mem_word_loc, mif.mem_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Read miss then hit.
        do_op(1'b0, 10'h084, 32'h0, 1'b0, rd);
        check_eq("plan_miss_w0", rd, 32'h11111111);
        do_op(1'b0, 10'h084, 32'h0, 1'b0, rd);
        check_eq("plan_hit_w0", rd, 32'h11111111);
        // Store hit.
        do_op(1'b1, 10'h086, 32'hDEADBEEF, 1'b0, rd);
        do_op(1'b0, 10'h086, 32'h0, 1'b0, rd);
        check_eq("plan_st_hit", rd, 32'hDEADBEEF);
        check_eq("plan_mem_w2", mem_blk[8'h21][95:64], 32'hDEADBEEF);
        // Store miss: no allocation, reload misses and sees the stored word.
        do_op(1'b1, 10'h3F0, 32'hCAFEF00D, 1'b0, rd);
        do_op(1'b0, 10'h3F0, 32'h0, 1'b0, rd);
        check_eq("plan_st_miss", rd, 32'hCAFEF00D);
        // Conflict on index 1.
        do_op(1'b0, 10'h004, 32'h0, 1'b0, rd);
        do_op(1'b0, 10'h084, 32'h0, 1'b0, rd);
        do_op(1'b0, 10'h004, 32'h0, 1'b0, rd);
        // Back-to-back cold loads with a two-cycle mem_done.
        force_hold = 2;
        do_op(1'b0, 10'h101, 32'h0, 1'b1, rd);
        do_op(1'b0, 10'h202, 32'h0, 1'b0, rd);
        force_hold = 0;

        // Reset while waiting in MEM_RD.
        force_lat = 8;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h303;
        @(posedge clk); #1;
        check_eq("pre_rst_re", mif.mem_re, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_out", {cpu_ready, cpu_stall, mif.mem_re, mif.mem_we}, 0);
        check_eq("mid_rst_data", {cpu_rdata, mif.mem_addr, mif.mem_word_loc}, 0);
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        force_lat = -1;
        for (int i = 0; i < CACHE_LINES; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
        check_eq("rst_hits", hit_count, 0);
        check_eq("rst_misses", miss_count, 0);
        rdy_cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (cpu_ready) rdy_cnt++;
        end
        check_eq("rst_no_rdy", rdy_cnt, 0);
        do_op(1'b0, 10'h084, 32'h0, 1'b0, rd);

        // Random traffic over a small footprint to mix hits, misses and conflicts.
        for (int i = 0; i < 300; i++) begin
            logic [ADDR_W-1:0] a;
            a = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_op($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(0, 1) == 1, rd);
        end
        repeat (10) @(posedge clk);
        #1;

`ifdef CACHE_STATS_EN
        check_eq("hit_count", hit_count, 16'(m_hits));
        check_eq("miss_count", miss_count, 16'(m_misses));
`else
        check_eq("hit_count", hit_count, 0);
        check_eq("miss_count", miss_count, 0);
`endif
        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem_blk[i] !== ref_mem[i]) nbad++;
        check_eq("mem_image", nbad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
